// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 latency-configurable memory responder.
package lc3_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} mem_ch_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h3000;

    function automatic int unsigned lat_width(input int unsigned max_lat);
        return (max_lat > 0) ? $clog2(max_lat + 1) : 1;
    endfunction

    function automatic logic [15:0] pick_latency(input logic [15:0] lfsr,
                                                 input int unsigned mode,
                                                 input int unsigned max_lat);
        if (mode == 0)
            return 16'(max_lat);
        return 16'(32'(lfsr) % (max_lat + 1));
    endfunction

endpackage

// File: rtl/lc3_mem_channel.sv
// One request/complete handshake channel: wait-state countdown, address capture
// and completed-transaction counter.
module lc3_mem_channel
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MAX_LAT = 4,
    localparam int unsigned CW     = lat_width(MAX_LAT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [CW-1:0]     lat,
    output logic              complete,
    output logic [31:0]       xact_cnt
);

    mem_ch_state_t     state;
    logic [ADDR_W-1:0] cap;
    logic [CW-1:0]     cnt;
    logic              addr_hit;
    logic              start;
    logic              first;

    // complete must rise in the request cycle for zero-wait accesses, so it is
    // decoded from the registered state rather than held in a flop.
    always_comb begin
        addr_hit = (addr == cap);
        start    = req && ((state == IDLE) || !addr_hit);
        complete = 1'b0;
        if (reset_n && req) begin
            if (start)
                complete = (lat == '0);
            else if (state == WAIT)
                complete = (cnt == '0);
            else
                complete = 1'b1;
        end
        first = complete && ((state != HOLD) || start);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cap      <= '0;
            cnt      <= '0;
            xact_cnt <= '0;
        end else begin
            if (first)
                xact_cnt <= xact_cnt + 32'd1;
            if (!req) begin
                state <= IDLE;
            end else if (start) begin
                cap <= addr;
                if (lat == '0) begin
                    state <= HOLD;
                end else begin
                    cnt   <= lat - CW'(1);
                    state <= WAIT;
                end
            end else if (state == WAIT) begin
                if (cnt == '0)
                    state <= HOLD;
                else
                    cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC3 instruction/data memory model with fixed or LFSR-driven wait states and a
// backdoor load port for program preloading.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 65536,
    parameter int unsigned T_FETCH_MAX = 4,
    parameter int unsigned T_DATA_MAX  = 0,
    parameter int unsigned LAT_MODE    = 0,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [15:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instrmem_rd,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              data_en,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic              Data_rd,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       data_cnt
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned FCW = lat_width(T_FETCH_MAX);
    localparam int unsigned DCW = lat_width(T_DATA_MAX);

    if (SEED == 16'h0 || 32'(BASE_ADDR) >= (32'd1 << ADDR_W)) begin : g_bad_param
        $error("lc3_mem_responder: SEED must be nonzero and BASE_ADDR must fit ADDR_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [15:0]       lfsr;
    logic [FCW-1:0]    lat_f;
    logic [DCW-1:0]    lat_d;
    logic [AW-1:0]     pc_idx;
    logic [AW-1:0]     d_idx;
    logic [AW-1:0]     ld_idx;

    function automatic logic [AW-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return AW'(32'(a) % DEPTH);
    endfunction

    always_comb begin
        pc_idx     = to_idx(pc);
        d_idx      = to_idx(Data_addr);
        ld_idx     = to_idx(ld_addr);
        Instr_dout = mem[pc_idx];
        Data_dout  = mem[d_idx];
        lat_f      = FCW'(pick_latency(lfsr, LAT_MODE, T_FETCH_MAX));
        lat_d      = DCW'(pick_latency(lfsr, LAT_MODE, T_DATA_MAX));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lfsr <= SEED;
        else
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    // Backdoor write is issued last so it overrides a core write to the same word.
    always_ff @(posedge clk) begin
        if (complete_data && !Data_rd)
            mem[d_idx] <= Data_din;
        if (ld_en)
            mem[ld_idx] <= ld_data;
    end

    lc3_mem_channel #(
        .ADDR_W  (ADDR_W),
        .MAX_LAT (T_FETCH_MAX)
    ) u_fetch (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (instrmem_rd),
        .addr     (pc),
        .lat      (lat_f),
        .complete (complete_instr),
        .xact_cnt (instr_cnt)
    );

    lc3_mem_channel #(
        .ADDR_W  (ADDR_W),
        .MAX_LAT (T_DATA_MAX)
    ) u_data (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (data_en),
        .addr     (Data_addr),
        .lat      (lat_d),
        .complete (complete_data),
        .xact_cnt (data_cnt)
    );

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Parametrised, latency-configurable instruction/data memory model that answers the LC3 core's fetch and data-memory requests in the verification environment. It replaces the zero-wait memory behaviour currently modelled inside the driver with synthesizable RTL. It inserts fixed or pseudo-random wait states, up to `T_FETCH_MAX` and `T_DATA_MAX`, before asserting `complete_instr` / `complete_data`. It sits between the `LC3` instance and the bench. A backdoor port lets the test preload programs starting at `BASE_ADDR`.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `DEPTH`, 65536: memory words; index = addr mod `DEPTH`.
- `T_FETCH_MAX`, 4: maximum instruction wait states.
- `T_DATA_MAX`, 0: maximum data wait states.
- `LAT_MODE`, 0: 0 = fixed latency (= max); 1 = LFSR pseudo-random in [0, max].
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `BASE_ADDR`, 16'h3000: documented program origin; used by the bench only.

Ports:
- `clk` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `instrmem_rd` in 1: fetch request.
- `pc` in ADDR_W: fetch address.
- `Instr_dout` out DATA_W: mem[pc], combinational.
- `complete_instr` out 1: fetch data valid.
- `data_en` in 1: data access request; the bench derives it from the core's memory state.
- `Data_addr` in ADDR_W: data address.
- `Data_rd` in 1: 1 = read, 0 = write.
- `Data_din` in DATA_W: write data from the core.
- `Data_dout` out DATA_W: mem[Data_addr], combinational.
- `complete_data` out 1: data access done.
- `ld_en` in 1: backdoor write strobe.
- `ld_addr` in ADDR_W: backdoor address.
- `ld_data` in DATA_W: backdoor data.
- `instr_cnt` out 32: completed fetch transactions.
- `data_cnt` out 32: completed data transactions.

## Operation
- Two independent channel FSMs, fetch and data, with identical logic. Each has states IDLE, WAIT, HOLD, plus a captured address `cap` and a down-counter `cnt` of width $clog2(max+1).
- Latency L: `LAT_MODE`=0 gives L = max; `LAT_MODE`=1 gives L = lfsr mod (max+1).
  - One shared 16-bit Fibonacci LFSR, taps 16,14,13,11, steps every cycle.
  - L is sampled combinationally when a request starts.
- IDLE:
  - req low: stay.
  - req high and L==0: complete is asserted combinationally in the same cycle; capture addr; go to HOLD.
  - req high and L>0: `cnt`<=L-1; capture addr; go to WAIT.
- WAIT:
  - req low: go to IDLE (request abandoned, no count increment).
  - addr != cap: restart as in IDLE with a freshly sampled L.
  - cnt==0: complete high this cycle; go to HOLD.
  - Otherwise decrement `cnt`.
- HOLD:
  - req high and addr==cap: complete stays high.
  - req low: go to IDLE.
  - addr changed with req high: treat as a new IDLE request in the same cycle (complete follows the L==0 rule).
- Counters increment once per transaction, on the cycle complete first rises.
- Writes: at every rising edge where `complete_data`=1 and `Data_rd`=0, mem[Data_addr] <= `Data_din`. Repeats while in HOLD are idempotent.
- Backdoor: `ld_en` writes mem[ld_addr] <= ld_data at the edge. It is allowed at any time.
- Same-edge collision between backdoor and core write to the same index: the backdoor wins.
- Read-during-write: a read in the same cycle returns the old value; the new value is visible the next cycle.
- Address index wraps modulo `DEPTH` for all three ports.

## Timing
- Request sampled high in cycle 0 with latency L: complete is high in cycle L and data is valid in that cycle. L==0 means zero-wait.
- Reset (asynchronous assert, synchronous-safe deassert):
  - FSMs go to IDLE.
  - `complete_*`=0, `cnt`=0, counters=0, lfsr=`SEED`.
  - Memory contents are retained.
- Reset mid-WAIT aborts the transaction without incrementing the counter.
- `Instr_dout`/`Data_dout` are combinational from the array at all times. They are meaningful only while complete is high.

## Structure
- Package `lc3_mem_pkg`:
  - `typedef enum logic [1:0] {IDLE, WAIT, HOLD} mem_ch_state_t`.
  - LFSR tap constant.
  - Default `BASE_ADDR`.
- Sub-module `lc3_mem_channel`: FSM, `cnt`, `cap` and `*_cnt`, parametrised by max latency. Instantiated twice.
- The top level holds the array, the LFSR, the write muxing and the backdoor port.

## Test plan
- Fixed mode, `T_FETCH_MAX`=4, preload mem[16'h3000]=16'h1021, `pc`=16'h3000 with rd high from cycle 0 -> `complete_instr` low in cycles 0–3, high from cycle 4 with `Instr_dout`=16'h1021, `instr_cnt`=1.
- `T_DATA_MAX`=0, write `Data_addr`=16'h4000, `Data_din`=16'hBEEF, `Data_rd`=0, then read the same address -> `complete_data` asserted in the same cycle as each request; the read returns 16'hBEEF.
- `pc` changes 16'h3000 -> 16'h3001 in cycle 2 of a 4-cycle wait -> complete stays low and first rises in cycle 6, with data = mem[16'h3001].
- Random mode, 1000 fetches, `T_FETCH_MAX`=4 -> every latency is in 0..4, all five values are observed, `instr_cnt`=1000.
- `reset_n` pulsed low during WAIT -> complete=0 immediately, counters=0, preloaded memory is unchanged.
- Backdoor and core write to 16'h5000 on the same edge (ld_data=16'h1111, Data_din=16'h2222) -> mem[16'h5000]=16'h1111. With `DEPTH`=4096, address 16'h1005 aliases 16'h0005.
